// File: rtl/aes_key_sched_seq.sv
// Sequential AES key expansion for 128/192/256-bit keys: one word per cycle through
// an Nk-word sliding window, emitting each 4-word round key over a valid/ready port.
module aes_key_sched_seq #(
    parameter int SBOX_REG = 0,
    parameter int KEY_W    = 256
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [1:0]         key_len,
    input  logic [KEY_W-1:0]   key_in,
    output logic               busy,
    output logic               rk_valid,
    input  logic               rk_ready,
    output logic [127:0]       rk_data,
    output logic [3:0]         rk_idx,
    output logic               rk_last,
    output logic               err
);

    // Forward S-box, byte 0x00 in the top eight bits.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {IDLE, LOAD, EXPAND, DRAIN} state_t;

    state_t             state_q;
    logic [KEY_W-1:0]   key_q;
    logic [31:0]        win_q [8];
    logic [5:0]         i_q;
    logic [2:0]         mod_q;
    logic [2:0]         nk_m1_q;
    logic [3:0]         nr_q;
    logic [7:0]         rcon_q;
    logic               ph_q;
    logic [31:0]        sub_q;
    logic               busy_q;
    logic               rk_valid_q;
    logic [127:0]       rk_data_q;
    logic [3:0]         rk_idx_q;
    logic               rk_last_q;
    logic               err_q;

    logic [31:0]        prev_w;
    logic [31:0]        far_w;
    logic [31:0]        sub_in;
    logic [31:0]        sub_bytes;
    logic [31:0]        sub_d;
    logic [31:0]        sub_use;
    logic [31:0]        word_d;
    logic               is_rcon;
    logic               is_sub8;
    logic               need_sub;
    logic               sub_wait;
    logic               grp_done;
    logic               stall;
    logic               gen_en;
    logic               handshake;
    logic               last_word;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sbox
            assign sub_bytes[gi*8 +: 8] = SBOX_TBL[{~sub_in[gi*8 +: 8], 3'b000} +: 8];
        end
    endgenerate

    always_comb begin
        prev_w = win_q[0];
        case (nk_m1_q)
            3'd3:    far_w = win_q[3];
            3'd5:    far_w = win_q[5];
            default: far_w = win_q[7];
        endcase
        is_rcon   = (mod_q == 3'd0);
        is_sub8   = (nk_m1_q == 3'd7) && (mod_q == 3'd4);
        need_sub  = (state_q == EXPAND) && (is_rcon || is_sub8);
        sub_in    = is_rcon ? {prev_w[23:0], prev_w[31:24]} : prev_w;
        sub_d     = sub_bytes ^ {(is_rcon ? rcon_q : 8'h00), 24'h000000};
        sub_use   = (SBOX_REG != 0) ? sub_q : sub_d;
        if (state_q == LOAD)
            word_d = key_q[KEY_W-1 -: 32];
        else
            word_d = far_w ^ ((is_rcon || is_sub8) ? sub_use : prev_w);
        handshake = rk_valid_q && rk_ready;
        grp_done  = (i_q[1:0] == 2'b11);
        // A completing word may only be produced if the output slot will be free.
        stall     = grp_done && rk_valid_q && !rk_ready;
        sub_wait  = (SBOX_REG != 0) && need_sub && !ph_q;
        gen_en    = ((state_q == LOAD) || (state_q == EXPAND)) && !stall && !sub_wait;
        last_word = (i_q == {nr_q, 2'b11});
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            key_q      <= '0;
            for (int k = 0; k < 8; k++) win_q[k] <= 32'h0;
            i_q        <= 6'd0;
            mod_q      <= 3'd0;
            nk_m1_q    <= 3'd3;
            nr_q       <= 4'd10;
            rcon_q     <= 8'h01;
            ph_q       <= 1'b0;
            sub_q      <= 32'h0;
            busy_q     <= 1'b0;
            rk_valid_q <= 1'b0;
            rk_data_q  <= 128'h0;
            rk_idx_q   <= 4'd0;
            rk_last_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (handshake)
                rk_valid_q <= 1'b0;
            if (sub_wait) begin
                sub_q <= sub_d;
                ph_q  <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (key_len == 2'b11) begin
                            err_q <= 1'b1;
                        end else begin
                            state_q <= LOAD;
                            busy_q  <= 1'b1;
                            key_q   <= key_in;
                            for (int k = 0; k < 8; k++) win_q[k] <= 32'h0;
                            i_q     <= 6'd0;
                            mod_q   <= 3'd0;
                            rcon_q  <= 8'h01;
                            ph_q    <= 1'b0;
                            case (key_len)
                                2'b00: begin nk_m1_q <= 3'd3; nr_q <= 4'd10; end
                                2'b01: begin nk_m1_q <= 3'd5; nr_q <= 4'd12; end
                                default: begin nk_m1_q <= 3'd7; nr_q <= 4'd14; end
                            endcase
                        end
                    end
                end
                LOAD, EXPAND: begin
                    if (gen_en) begin
                        for (int k = 7; k > 0; k--) win_q[k] <= win_q[k-1];
                        win_q[0] <= word_d;
                        i_q      <= i_q + 6'd1;
                        mod_q    <= (mod_q == nk_m1_q) ? 3'd0 : mod_q + 3'd1;
                        ph_q     <= 1'b0;
                        if (state_q == LOAD)
                            key_q <= {key_q[KEY_W-33:0], 32'h0};
                        if (state_q == LOAD && i_q == {3'b000, nk_m1_q})
                            state_q <= EXPAND;
                        if (state_q == EXPAND && is_rcon)
                            rcon_q <= {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
                        // The three previous words of the group are still in the window.
                        if (grp_done) begin
                            rk_valid_q <= 1'b1;
                            rk_data_q  <= {win_q[2], win_q[1], win_q[0], word_d};
                            rk_idx_q   <= i_q[5:2];
                            rk_last_q  <= last_word;
                            if (last_word)
                                state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (handshake) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign rk_valid = rk_valid_q;
    assign rk_data  = rk_data_q;
    assign rk_idx   = rk_idx_q;
    assign rk_last  = rk_last_q;
    assign err      = err_q;

endmodule

// File: tb/tb_aes_key_sched_seq.sv
// Bench for aes_key_sched_seq: a combinational-S-box and a registered-S-box instance share
// stimulus; a reference expansion fills a scoreboard that both output ports drain.
module tb_aes_key_sched_seq;

    typedef struct packed {
        logic [3:0]   idx;
        logic         last;
        logic [127:0] data;
    } exp_t;

    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         rk_ready = 1'b1;
    logic [1:0]   key_len = 2'b00;
    logic [255:0] key_in = '0;

    logic         busy_o [2];
    logic         rkv [2];
    logic         rkl [2];
    logic         err_o [2];
    logic [127:0] rkd [2];
    logic [3:0]   rki [2];

    int           n_cmp = 0;
    int           n_bad = 0;
    exp_t         expq [$];
    int           rd [2];
    int           n_rx [2];
    logic [127:0] rec [2][16];
    logic         hold_q [2];
    logic [132:0] held [2];

    always #5 clk = ~clk;

    aes_key_sched_seq #(.SBOX_REG(0), .KEY_W(256)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .key_len(key_len), .key_in(key_in),
        .busy(busy_o[0]), .rk_valid(rkv[0]), .rk_ready(rk_ready), .rk_data(rkd[0]),
        .rk_idx(rki[0]), .rk_last(rkl[0]), .err(err_o[0])
    );

    aes_key_sched_seq #(.SBOX_REG(1), .KEY_W(256)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .key_len(key_len), .key_in(key_in),
        .busy(busy_o[1]), .rk_valid(rkv[1]), .rk_ready(rk_ready), .rk_data(rkd[1]),
        .rk_idx(rki[1]), .rk_last(rkl[1]), .err(err_o[1])
    );

    task automatic chk(input string tag, input logic [135:0] obs, input logic [135:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int k = 0; k < 8; k++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse (x^254) then the affine map.
    function automatic logic [7:0] sb(input logic [7:0] x);
        logic [7:0] r = 8'h01;
        logic [7:0] s = x;
        for (int k = 1; k < 8; k++) begin
            s = gmul(s, s);
            r = gmul(r, s);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] x);
        return {sb(x[31:24]), sb(x[23:16]), sb(x[15:8]), sb(x[7:0])};
    endfunction

    task automatic new_sched(input logic [255:0] key, input logic [1:0] kl);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rcon = 8'h01;
        int          nk = (kl == 2'b00) ? 4 : (kl == 2'b01) ? 6 : 8;
        int          nr = nk + 6;
        exp_t        e;
        expq.delete();
        for (int d = 0; d < 2; d++) begin rd[d] = 0; n_rx[d] = 0; end
        if (kl != 2'b11) begin
            for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
            for (int i = nk; i < 4*nr + 4; i++) begin
                t = w[i-1];
                if (i % nk == 0) begin
                    t = subw({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                    rcon = rcon[7] ? ({rcon[6:0], 1'b0} ^ 8'h1b) : {rcon[6:0], 1'b0};
                end else if (nk == 8 && i % 8 == 4) begin
                    t = subw(t);
                end
                w[i] = w[i-nk] ^ t;
            end
            for (int r = 0; r <= nr; r++) begin
                e.idx  = 4'(r);
                e.last = (r == nr);
                e.data = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
                expq.push_back(e);
            end
        end
    endtask

    task automatic drive_start(input logic [255:0] key, input logic [1:0] kl);
        key_in  = key;
        key_len = kl;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
    endtask

    task automatic wait_done(input int n_exp, input string tag);
        int cyc = 0;
        while (!(rd[0] == expq.size() && rd[1] == expq.size() && !busy_o[0] && !busy_o[1])
               && cyc < 3000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        n_cmp++;
        assert (cyc < 3000) else begin
            n_bad++;
            $error("FAIL timeout_%s waited=%0d limit=3000", tag, cyc);
        end
        for (int d = 0; d < 2; d++)
            chk($sformatf("nkeys_%s_dut%0d", tag, d), 136'(n_rx[d]), 136'(n_exp));
    endtask

    // Scoreboard drain: a handshake happens at the next rising edge whenever valid and
    // ready are both high now; a key held under backpressure must not change.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst_n && hold_q[d])
                chk($sformatf("hold_dut%0d", d), 136'({rkv[d], rki[d], rkl[d], rkd[d]}),
                    136'({1'b1, held[d]}));
            if (rst_n && rkv[d] && rk_ready) begin
                if (rd[d] < expq.size()) begin
                    chk($sformatf("key_dut%0d_r%0d", d, rd[d]), 136'({rki[d], rkl[d], rkd[d]}),
                        136'(expq[rd[d]]));
                    rd[d]++;
                end else begin
                    n_cmp++;
                    assert (rd[d] < expq.size()) else begin
                        n_bad++;
                        $error("FAIL extra_key_dut%0d observed idx=%0d expected none", d, rki[d]);
                    end
                end
                rec[d][rki[d]] = rkd[d];
                n_rx[d]++;
            end
            hold_q[d] = rst_n && rkv[d] && !rk_ready;
            held[d]   = {rki[d], rkl[d], rkd[d]};
        end
    end

    initial begin
        int  cnt;
        logic stalled;
        logic found;
        for (int d = 0; d < 2; d++) begin
            rd[d] = 0; n_rx[d] = 0; hold_q[d] = 1'b0; held[d] = '0;
        end

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++)
            chk($sformatf("reset_dut%0d", d),
                136'({busy_o[d], rkv[d], rki[d], rkl[d], err_o[d], rkd[d]}), 136'(0));

        // 128-bit key, always ready: latency and cadence
        new_sched(K128, 2'b00);
        drive_start(K128, 2'b00);
        chk("busy_after_accept", 136'(busy_o[0]), 136'(1));
        cnt = 0;
        while (!rkv[0] && cnt < 20) begin @(posedge clk); #1; cnt++; end
        chk("latency_r0", 136'(cnt), 136'(4));
        cnt = 0;
        do begin @(posedge clk); #1; cnt++; end while (!(rkv[0] && rki[0] == 4'd1) && cnt < 20);
        chk("cadence_r1", 136'(cnt), 136'(4));
        wait_done(11, "k128");
        chk("k128_r1", 136'(rec[0][1]), 136'(128'ha0fafe1788542cb123a339392a6c7605));
        chk("k128_r10_dut0", 136'(rec[0][10]), 136'(128'hd014f9a8c9ee2589e13f0cc8b6630ca6));
        chk("k128_r10_dut1", 136'(rec[1][10]), 136'(128'hd014f9a8c9ee2589e13f0cc8b6630ca6));

        // 192-bit key
        new_sched(K192, 2'b01);
        drive_start(K192, 2'b01);
        wait_done(13, "k192");
        chk("k192_r12_dut0", 136'(rec[0][12]), 136'(128'he98ba06f448c773c8ecc720401002202));
        chk("k192_r12_dut1", 136'(rec[1][12]), 136'(128'he98ba06f448c773c8ecc720401002202));

        // 256-bit key
        new_sched(K256, 2'b10);
        drive_start(K256, 2'b10);
        wait_done(15, "k256");
        chk("k256_r14_dut0", 136'(rec[0][14]), 136'(128'hfe4890d1e6188d0b046df344706c631e));
        chk("k256_r14_dut1", 136'(rec[1][14]), 136'(128'hfe4890d1e6188d0b046df344706c631e));

        // 256-bit key under random backpressure with a long stall at r=3
        new_sched(K256, 2'b10);
        drive_start(K256, 2'b10);
        stalled = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if (rd[0] == expq.size() && rd[1] == expq.size()) break;
            @(posedge clk);
            #1;
            if (!stalled && rkv[0] && rki[0] == 4'd3) begin
                rk_ready = 1'b0;
                repeat (20) begin @(posedge clk); #1; end
                chk("stall_r3_held", 136'({rkv[0], rki[0]}), 136'({1'b1, 4'd3}));
                stalled = 1'b1;
            end
            rk_ready = 1'($urandom_range(0, 1));
        end
        rk_ready = 1'b1;
        wait_done(15, "k256_bp");

        // Illegal key length
        new_sched(K128, 2'b11);
        drive_start(K128, 2'b11);
        for (int d = 0; d < 2; d++)
            chk($sformatf("err_pulse_dut%0d", d), 136'({err_o[d], busy_o[d]}), 136'({1'b1, 1'b0}));
        @(posedge clk);
        #1;
        chk("err_clear", 136'({err_o[0], err_o[1]}), 136'(0));
        repeat (10) begin @(posedge clk); #1; end
        chk("err_no_output", 136'({rkv[0], rkv[1], busy_o[0], busy_o[1]}), 136'(0));

        // Reset while r=5 is presented
        new_sched(K128, 2'b00);
        drive_start(K128, 2'b00);
        found = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (rkv[0] && rki[0] == 4'd5) begin found = 1'b1; break; end
            @(posedge clk);
            #1;
        end
        chk("reach_r5", 136'(found), 136'(1));
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++)
            chk($sformatf("reset_mid_dut%0d", d),
                136'({busy_o[d], rkv[d], rki[d], rkl[d], err_o[d], rkd[d]}), 136'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        new_sched(K128, 2'b11);
        repeat (10) begin @(posedge clk); #1; end
        chk("post_reset_quiet", 136'({rkv[0], rkv[1], busy_o[0], busy_o[1]}), 136'(0));

        // First start after reset, with a second start attempted while busy
        new_sched(K192, 2'b01);
        drive_start(K192, 2'b01);
        repeat (8) begin @(posedge clk); #1; end
        key_len = 2'b10;
        key_in  = K256;
        start   = 1'b1;
        repeat (6) begin @(posedge clk); #1; end
        start   = 1'b0;
        wait_done(13, "k192_after_reset");
        chk("k192b_r12_dut0", 136'(rec[0][12]), 136'(128'he98ba06f448c773c8ecc720401002202));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
